// File: rtl/dcache_bypass_arb_if.sv
// Wide memory-bus bundle between the data-cache front end and the memory system.
// The master drives requests; the slave returns read data and completions.
interface dcache_bypass_arb_if #(
   parameter int unsigned ADDR_WIDTH = 64,
   parameter int unsigned MEM_WIDTH  = 128
);
   logic [ADDR_WIDTH-1:0]  mem_raddr;
   logic                   mem_ren;
   logic [MEM_WIDTH-1:0]   mem_rdata;
   logic                   mem_rvalid;
   logic [ADDR_WIDTH-1:0]  mem_waddr;
   logic                   mem_wen;
   logic [MEM_WIDTH-1:0]   mem_wdata;
   logic [MEM_WIDTH/8-1:0] mem_wmask;
   logic                   mem_wvalid;

   modport master (
      output mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata, mem_wmask,
      input  mem_rdata, mem_rvalid, mem_wvalid
   );

   modport slave (
      input  mem_raddr, mem_ren, mem_waddr, mem_wen, mem_wdata, mem_wmask,
      output mem_rdata, mem_rvalid, mem_wvalid
   );
endinterface

// File: rtl/dcache_bypass_arb.sv
// Data-cache front end: routes CPU accesses to the cache core or an uncached bypass with a
// posted write buffer, and arbitrates both onto a single wide memory port.
module dcache_bypass_arb #(
   parameter int unsigned           ADDR_WIDTH = 64,
   parameter int unsigned           DATA_WIDTH = 64,
   parameter int unsigned           LANES      = 2,
   parameter int unsigned           WBUF_DEPTH = 4,
   parameter logic [ADDR_WIDTH-1:0] UC_BASE    = 64'h1000_0000,
   parameter logic [ADDR_WIDTH-1:0] UC_SIZE    = 64'h1000_0000
) (
   input  logic                                  clk,
   input  logic                                  rst,
   // CPU side
   input  logic [ADDR_WIDTH-1:0]                 addr_cpu,
   input  logic [DATA_WIDTH-1:0]                 wdata_cpu,
   input  logic [DATA_WIDTH/8-1:0]               wmask_cpu,
   input  logic                                  wen_cpu,
   input  logic                                  ren_cpu,
   output logic [DATA_WIDTH-1:0]                 rdata_cpu,
   output logic                                  stall_cpu,
   input  logic                                  cache_enable,
   output logic                                  cache_mode,
   // Cache core side
   output logic                                  c_wen,
   output logic                                  c_ren,
   input  logic [DATA_WIDTH-1:0]                 c_rdata,
   input  logic                                  c_hit,
   input  logic [ADDR_WIDTH-1:0]                 c_mem_raddr,
   input  logic                                  c_mem_ren,
   input  logic [ADDR_WIDTH-1:0]                 c_mem_waddr,
   input  logic                                  c_mem_wen,
   input  logic [LANES*DATA_WIDTH-1:0]           c_mem_wdata,
   input  logic [LANES*DATA_WIDTH/8-1:0]         c_mem_wmask,
   output logic                                  c_mem_rvalid,
   output logic                                  c_mem_wvalid,
   output logic [LANES*DATA_WIDTH-1:0]           c_mem_rdata,
   // Memory bus
   dcache_bypass_arb_if.master                   bus
);

   localparam int unsigned MEM_WIDTH = LANES * DATA_WIDTH;
   localparam int unsigned STRB_W    = DATA_WIDTH / 8;
   localparam int unsigned MSTRB_W   = MEM_WIDTH / 8;
   localparam int unsigned OFF_W     = $clog2(STRB_W);
   localparam int unsigned LANE_W    = (LANES > 1) ? $clog2(LANES) : 1;
   localparam int unsigned IDX_W     = $clog2(WBUF_DEPTH);
   localparam int unsigned PTR_W     = IDX_W + 1;

   localparam logic [ADDR_WIDTH-1:0] UC_MASK = ~(UC_SIZE - ADDR_WIDTH'(1));

   typedef enum logic [1:0] {OwnNone, OwnCache, OwnByp} owner_e;
   typedef enum logic [1:0] {StIdle, StWdrain, StRd} byp_st_e;

   owner_e                  owner_q;
   byp_st_e                 byp_st_q;
   logic                    cache_mode_q;
   logic [PTR_W-1:0]        wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH-1:0]   rd_addr_q;

   logic [ADDR_WIDTH-1:0]   wb_addr_q [WBUF_DEPTH];
   logic [MEM_WIDTH-1:0]    wb_data_q [WBUF_DEPTH];
   logic [MSTRB_W-1:0]      wb_mask_q [WBUF_DEPTH];

   logic                    in_win, uc, uc_wr, uc_rd;
   logic [LANE_W-1:0]       lane;
   logic [IDX_W-1:0]        wr_idx, rd_idx;
   logic                    empty, full;
   logic                    push, pop, wr_done, rd_done;
   logic [PTR_W-1:0]        wb_count_next;
   logic                    wb_pending, cache_req, rd_ready, arb_free, mode_ok;

   // Routing
   assign in_win = (addr_cpu & UC_MASK) == UC_BASE;
   assign uc     = ~cache_mode_q | in_win;
   assign uc_wr  = wen_cpu & uc;
   assign uc_rd  = ren_cpu & uc & ~wen_cpu;
   assign c_wen  = wen_cpu & ~uc;
   assign c_ren  = ren_cpu & ~uc;
   assign lane   = LANE_W'(addr_cpu >> OFF_W) & LANE_W'(LANES - 1);

   // Write buffer bookkeeping; the extra pointer bit separates full from empty
   assign wr_idx = wr_ptr_q[IDX_W-1:0];
   assign rd_idx = rd_ptr_q[IDX_W-1:0];
   assign empty  = wr_ptr_q == rd_ptr_q;
   assign full   = (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]) && (wr_idx == rd_idx);

   assign wr_done = (byp_st_q == StWdrain) & bus.mem_wvalid;
   assign rd_done = (byp_st_q == StRd) & bus.mem_rvalid;
   assign pop     = wr_done;
   // A full buffer still accepts a store in the cycle its head retires
   assign push    = uc_wr & (~full | pop);

   assign wb_count_next = wr_ptr_q - rd_ptr_q + PTR_W'(push) - PTR_W'(pop);
   assign wb_pending    = wb_count_next != '0;
   assign cache_req     = c_mem_ren | c_mem_wen;
   assign rd_ready      = (owner_q == OwnNone) & (byp_st_q == StIdle) & uc_rd & empty;
   // A retiring drain re-arbitrates at once so queued stores can stream back to back
   assign arb_free      = (owner_q == OwnNone) | wr_done;
   assign mode_ok       = (owner_q == OwnNone) & empty & (byp_st_q == StIdle) &
                          ~ren_cpu & ~wen_cpu;

   always_ff @(posedge clk) begin
      if (push) begin
         wb_addr_q[wr_idx] <= addr_cpu;
         wb_data_q[wr_idx] <= {LANES{wdata_cpu}};
         wb_mask_q[wr_idx] <= MSTRB_W'(wmask_cpu) << (lane * STRB_W);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= OwnNone;
         byp_st_q     <= StIdle;
         cache_mode_q <= 1'b0;
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         rd_addr_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_q + PTR_W'(push);
         rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
         if (mode_ok) begin
            cache_mode_q <= cache_enable;
         end
         if (arb_free) begin
            if (cache_req && !full) begin
               owner_q  <= OwnCache;
               byp_st_q <= StIdle;
            end else if (wb_pending) begin
               owner_q  <= OwnByp;
               byp_st_q <= StWdrain;
            end else if (rd_ready) begin
               owner_q   <= OwnByp;
               byp_st_q  <= StRd;
               rd_addr_q <= addr_cpu;
            end else begin
               owner_q  <= OwnNone;
               byp_st_q <= StIdle;
            end
         end else if (owner_q == OwnCache && (bus.mem_rvalid || bus.mem_wvalid)) begin
            owner_q <= OwnNone;
         end else if (rd_done) begin
            owner_q  <= OwnNone;
            byp_st_q <= StIdle;
         end
      end
   end

   assign cache_mode = cache_mode_q;

   // Bus steering: only the owner drives the bus or sees its responses
   always_comb begin
      bus.mem_raddr = '0;
      bus.mem_ren   = 1'b0;
      bus.mem_waddr = '0;
      bus.mem_wen   = 1'b0;
      bus.mem_wdata = '0;
      bus.mem_wmask = '0;
      c_mem_rvalid  = 1'b0;
      c_mem_wvalid  = 1'b0;
      c_mem_rdata   = '0;
      unique case (owner_q)
         OwnCache: begin
            bus.mem_raddr = c_mem_raddr;
            bus.mem_ren   = c_mem_ren;
            bus.mem_waddr = c_mem_waddr;
            bus.mem_wen   = c_mem_wen;
            bus.mem_wdata = c_mem_wdata;
            bus.mem_wmask = c_mem_wmask;
            c_mem_rvalid  = bus.mem_rvalid;
            c_mem_wvalid  = bus.mem_wvalid;
            c_mem_rdata   = bus.mem_rdata;
         end
         OwnByp: begin
            if (byp_st_q == StRd) begin
               bus.mem_raddr = rd_addr_q;
               bus.mem_ren   = 1'b1;
            end else if (byp_st_q == StWdrain) begin
               bus.mem_waddr = wb_addr_q[rd_idx];
               bus.mem_wen   = 1'b1;
               bus.mem_wdata = wb_data_q[rd_idx];
               bus.mem_wmask = wb_mask_q[rd_idx];
            end
         end
         default: begin
         end
      endcase
   end

   always_comb begin
      stall_cpu = 1'b0;
      rdata_cpu = '0;
      if (!uc) begin
         stall_cpu = (ren_cpu | wen_cpu) & ~c_hit;
         rdata_cpu = c_rdata;
      end else if (uc_wr) begin
         stall_cpu = ~push;
      end else if (uc_rd) begin
         stall_cpu = ~rd_done;
         if (rd_done) begin
            rdata_cpu = bus.mem_rdata[lane * DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

endmodule

// File: doc/dcache_bypass_arb.md
# dcache_bypass_arb

Memory-side front end for the data cache: routes each CPU data access either to the cache core or to an uncached bypass path, posts uncached stores into a write buffer, and arbitrates both sources onto one wide memory port. Successor to the single-mode cache/direct wrapper. It adds an address-windowed uncached region, configurable memory-bus width (lane count), a posted write buffer with read-after-write ordering, and a drain-before-switch cache mode change. It sits between the MEM-stage CPU port, the cache core, and the memory bus.

## Interface
- ADDR_WIDTH, 64, address width
- DATA_WIDTH, 64, CPU data width
- LANES, 2, memory-bus width in CPU words (power of two ≥1); MEM_WIDTH = LANES*DATA_WIDTH
- WBUF_DEPTH, 4, posted uncached-write entries (power of two ≥2)
- UC_BASE, 64'h1000_0000, uncached window base
- UC_SIZE, 64'h1000_0000, uncached window size (power of two, base aligned)

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  synchronous, active-high reset
- addr_cpu / wdata_cpu / wmask_cpu  in  ADDR_WIDTH / DATA_WIDTH / DATA_WIDTH/8  CPU access
- wen_cpu, ren_cpu  in  1  CPU write/read request
- rdata_cpu  out  DATA_WIDTH  read data
- stall_cpu  out  1  hold CPU request
- cache_enable  in  1  requested mode
- cache_mode  out  1  effective mode register
- c_wen, c_ren  out  1  gated request to cache core (addr/wdata/wmask pass through)
- c_rdata  in  DATA_WIDTH; c_hit  in  1  cache core response
- c_mem_raddr/c_mem_ren/c_mem_waddr/c_mem_wen/c_mem_wdata/c_mem_wmask  in  cache-core refill/writeback request (MEM_WIDTH data)
- c_mem_rvalid/c_mem_wvalid  out  1; c_mem_rdata  out  MEM_WIDTH  responses to cache core
- mem_raddr, mem_ren, mem_rdata, mem_rvalid, mem_waddr, mem_wen, mem_wdata, mem_wmask, mem_wvalid  memory bus (out/out/in/in/out/out/out/out/in), MEM_WIDTH data, MEM_WIDTH/8 mask

## Operation
- Route: uc = ~cache_mode | (addr_cpu within [UC_BASE, UC_BASE+UC_SIZE)). c_wen/c_ren = request & ~uc.
- Lane = addr_cpu[log2(DATA_WIDTH/8) +: log2(LANES)]. For LANES=1, the lane is 0.
- Uncached write: the entry {addr, wdata replicated to all lanes, wmask shifted to lane} is pushed if the buffer is not full. stall_cpu=0 in the push cycle. If the buffer is full, stall_cpu=1 until a pop frees space.
- Uncached read: stall until the buffer is empty and no bypass write is in flight. The read is then issued on mem. rdata_cpu = lane slice of mem_rdata in the mem_rvalid cycle.
- Cached access: stall_cpu = (ren|wen) & ~c_hit; rdata_cpu = c_rdata.
- Bypass FSM: IDLE → WDRAIN (buffer non-empty, granted) → IDLE on mem_wvalid (pop). IDLE → RD (uncached read pending, buffer empty, granted) → IDLE on mem_rvalid.
- Arbiter owner: NONE/CACHE/BYP. The owner holds the bus until its transaction completes (rvalid/wvalid). There is no preemption. When the owner is NONE:
  - a cache request wins, unless the buffer is full;
  - if the buffer is full, the bypass path wins.
- Bus steering: the non-owner sees valid=0 and rdata=0. The mem_* outputs are driven only by the owner; with owner NONE they are 0.
- Mode switch: cache_mode ← cache_enable only when:
  - owner=NONE,
  - the buffer is empty,
  - the bypass FSM is IDLE, and
  - there is no pending CPU request.
  While the mode differs from the request, new uncached writes still push.

## Timing
- Reset values:
  - outputs: cache_mode=0, stall_cpu=0, all mem_* and c_mem_* valids=0, rdata_cpu=0;
  - internal: FIFO pointers=0, owner NONE, FSM IDLE.
- Reset mid-transaction: the buffer is discarded and mem_ren/mem_wen drop the next cycle.
- Posted write: pushed at edge N. Earliest mem_wen is at N+1.
- Back-to-back drains: a pop at edge N presents the next head at N+1.
- Uncached read: stall_cpu falls in the cycle mem_rvalid=1; data is combinational from mem_rdata.
- Simultaneous push and pop when the buffer is full is allowed: stall_cpu=0 and the count is unchanged.
- FIFO pointers wrap modulo WBUF_DEPTH. full/empty use an extra pointer bit.
- The mode register updates at the first edge where the switch condition holds. cache_mode reflects the new mode in the following cycle.

## Test plan
- Reset then cached read miss at 0x8000_0040: c_ren=1, stall while c_hit=0, owner CACHE forwards the refill → stall clears when c_hit=1.
- cache_mode=1, write 0x1000_0008 wdata=0xAB, wmask=0x01, LANES=2 → stall_cpu=0; next cycle mem_wen=1, mem_wmask=0x0100, upper lane=0xAB.
- Five uncached writes back to back with mem_wvalid held low → writes 1-4 do not stall, write 5 stalls until the first mem_wvalid, then pushes.
- Uncached write to 0x1000_0000, then read of 0x1000_0000 → mem_ren stays 0 until the write's mem_wvalid; the read returns the written value.
- cache_enable 0→1 while two writes are buffered → cache_mode stays 0 until both pop and the bus is idle, then becomes 1.
- Reset asserted while mem_ren=1 → mem_ren=0, stall_cpu=0, buffer empty, cache_mode=0 the next cycle.
